// File: rtl/shift_pattern_monitor.sv
// rtl/shift_pattern_monitor.sv - detects Y==PAT held for HOLD enabled samples; hit pulse, saturating count.
module shift_pattern_monitor #(
   parameter int WIDTH = 4,
   parameter int HOLD  = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             R,
   input  logic             en,
   input  logic [WIDTH-1:0] Y,
   input  logic [WIDTH-1:0] PAT,
   input  logic             clr,
   output logic             hit,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf,
   output logic             busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_LOCK = 2'd2;
   localparam logic [3:0] HOLD_C = 4'(HOLD);

   logic [1:0]       state_q, state_d;
   logic [3:0]       hcnt_q, hcnt_d;
   logic             hit_q, hit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
   logic             ovf_q, ovf_d, ovf_base;
   logic             go;
   logic [3:0]       hcnt_inc;

   assign go       = en && (Y == PAT);
   assign hcnt_inc = hcnt_q + 4'd1;

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      hit_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               hcnt_d = 4'd1;
               if (HOLD_C == 4'd1) begin
                  state_d = S_LOCK;
                  hit_d   = 1'b1;
               end else begin
                  state_d = S_ARM;
               end
            end else begin
               hcnt_d = 4'd0;
            end
         end
         S_ARM: begin
            if (!go) begin
               state_d = S_IDLE;
               hcnt_d  = 4'd0;
            end else begin
               hcnt_d = hcnt_inc;
               if (hcnt_inc == HOLD_C) begin
                  state_d = S_LOCK;
                  hit_d   = 1'b1;
               end
            end
         end
         S_LOCK: begin
            // Held match never re-fires; a break is required before the next hit.
            if (!go) begin
               state_d = S_IDLE;
               hcnt_d  = 4'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
            hcnt_d  = 4'd0;
         end
      endcase
   end

   // clr is applied first so a coincident hit lands on a freshly cleared counter.
   always_comb begin
      cnt_base = clr ? '0 : cnt_q;
      ovf_base = clr ? 1'b0 : ovf_q;
      cnt_d    = cnt_base;
      ovf_d    = ovf_base;
      if (hit_d) begin
         if (cnt_base == {CNT_W{1'b1}}) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_base + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!R) begin
         state_q <= S_IDLE;
         hcnt_q  <= 4'd0;
         hit_q   <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         hit_q   <= hit_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign hit  = hit_q;
   assign cnt  = cnt_q;
   assign ovf  = ovf_q;
   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_pattern_monitor.sv
// tb/tb_shift_pattern_monitor.sv - randomized and directed checks against a run-length reference model.
module tb_shift_pattern_monitor;

   localparam int WIDTH = 4;
   localparam int HOLD  = 3;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             R   = 1'b0;
   logic             en  = 1'b0;
   logic [WIDTH-1:0] Y   = '0;
   logic [WIDTH-1:0] PAT = 4'b1111;
   logic             clr = 1'b0;
   logic             hit;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic             busy;

   int pass_cnt = 0;
   int total    = 0;

   // reference model: length of the current enabled matching run
   int   streak = 0;
   logic m_hit  = 1'b0;
   logic m_busy = 1'b0;
   logic m_ovf  = 1'b0;
   int   m_cnt  = 0;
   int   hits_seen;

   shift_pattern_monitor #(.WIDTH(WIDTH), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
      .clk(clk), .R(R), .en(en), .Y(Y), .PAT(PAT), .clr(clr),
      .hit(hit), .cnt(cnt), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r_v, input logic en_v, input logic [WIDTH-1:0] y_v, input logic clr_v);
      R = r_v; en = en_v; Y = y_v; clr = clr_v;
      @(posedge clk);
      if (!r_v) begin
         streak = 0; m_hit = 1'b0; m_cnt = 0; m_ovf = 1'b0;
      end else begin
         streak = (en_v && (y_v == PAT)) ? streak + 1 : 0;
         m_hit  = (streak == HOLD);
         if (clr_v) begin
            m_cnt = 0; m_ovf = 1'b0;
         end
         if (m_hit) begin
            if (m_cnt == CMAX) m_ovf = 1'b1;
            else m_cnt = m_cnt + 1;
         end
      end
      m_busy = (streak > 0);
      #1;
      if (hit === 1'b1) hits_seen++;
   endtask

   task automatic test_reset();
      PAT = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 4'b1111, 1'b0);
         total++;
         if ({hit, busy, ovf, cnt} !== {1'b0, 1'b0, 1'b0, 2'd0})
            $display("FAIL reset[%0d]: hit/busy/ovf/cnt=%b/%b/%b/%0d required 0/0/0/0", i, hit, busy, ovf, cnt);
         else pass_cnt++;
      end
      step(1'b1, 1'b1, 4'b1111, 1'b0);
      total++;
      if ({hit, busy} !== 2'b01)
         $display("FAIL reset_release: hit/busy=%b/%b required 0/1", hit, busy);
      else pass_cnt++;
      step(1'b1, 1'b0, 4'b0000, 1'b1);
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] seq [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
      hits_seen = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, seq[i], 1'b0);
         total++;
         if ({hit, busy, ovf, cnt} !== {m_hit, m_busy, m_ovf, CNT_W'(m_cnt)})
            $display("FAIL basic[%0d]: hit/busy/ovf/cnt=%b/%b/%b/%0d required %b/%b/%b/%0d",
                     i, hit, busy, ovf, cnt, m_hit, m_busy, m_ovf, m_cnt);
         else pass_cnt++;
      end
      total++;
      if (hits_seen !== 1 || cnt !== 2'd1)
         $display("FAIL basic_total: hits=%0d cnt=%0d required 1/1", hits_seen, cnt);
      else pass_cnt++;
   endtask

   task automatic test_broken();
      logic [WIDTH-1:0] seq [6] = '{4'hF, 4'hF, 4'h7, 4'hF, 4'hF, 4'hF};
      step(1'b1, 1'b1, 4'h0, 1'b1);
      hits_seen = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, seq[i], 1'b0);
         total++;
         if ({hit, busy, ovf, cnt} !== {m_hit, m_busy, m_ovf, CNT_W'(m_cnt)})
            $display("FAIL broken[%0d]: hit/busy/ovf/cnt=%b/%b/%b/%0d required %b/%b/%b/%0d",
                     i, hit, busy, ovf, cnt, m_hit, m_busy, m_ovf, m_cnt);
         else pass_cnt++;
      end
      total++;
      if (hits_seen !== 1 || hit !== 1'b1 || cnt !== 2'd1)
         $display("FAIL broken_total: hits=%0d hit=%b cnt=%0d required 1/1/1", hits_seen, hit, cnt);
      else pass_cnt++;
   endtask

   task automatic test_en_gating();
      logic en_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      step(1'b1, 1'b1, 4'h0, 1'b1);
      hits_seen = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, en_seq[i], 4'hF, 1'b0);
         total++;
         if ({hit, busy, ovf, cnt} !== {m_hit, m_busy, m_ovf, CNT_W'(m_cnt)})
            $display("FAIL en_gating[%0d]: hit/busy/ovf/cnt=%b/%b/%b/%0d required %b/%b/%b/%0d",
                     i, hit, busy, ovf, cnt, m_hit, m_busy, m_ovf, m_cnt);
         else pass_cnt++;
      end
      total++;
      if (hits_seen !== 1 || hit !== 1'b1)
         $display("FAIL en_gating_total: hits=%0d last hit=%b required 1/1", hits_seen, hit);
      else pass_cnt++;
   endtask

   task automatic test_rearm();
      logic [WIDTH-1:0] seq [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF};
      step(1'b1, 1'b1, 4'h0, 1'b1);
      hits_seen = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, seq[i], 1'b0);
         total++;
         if ({hit, busy, ovf, cnt} !== {m_hit, m_busy, m_ovf, CNT_W'(m_cnt)})
            $display("FAIL rearm[%0d]: hit/busy/ovf/cnt=%b/%b/%b/%0d required %b/%b/%b/%0d",
                     i, hit, busy, ovf, cnt, m_hit, m_busy, m_ovf, m_cnt);
         else pass_cnt++;
      end
      total++;
      if (hits_seen !== 2 || cnt !== 2'd2)
         $display("FAIL rearm_total: hits=%0d cnt=%0d required 2/2", hits_seen, cnt);
      else pass_cnt++;
   endtask

   task automatic test_saturation();
      step(1'b1, 1'b1, 4'h0, 1'b1);
      for (int h = 1; h <= 5; h++) begin
         for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hF, 1'b0);
         total++;
         if (hit !== 1'b1 || cnt !== CNT_W'((h > 3) ? 3 : h) || ovf !== (h >= 4))
            $display("FAIL saturation hit%0d: hit/cnt/ovf=%b/%0d/%b required 1/%0d/%b",
                     h, hit, cnt, ovf, (h > 3) ? 3 : h, (h >= 4));
         else pass_cnt++;
         step(1'b1, 1'b1, 4'h0, 1'b0);
      end
      step(1'b1, 1'b1, 4'hF, 1'b0);
      step(1'b1, 1'b1, 4'hF, 1'b0);
      step(1'b1, 1'b1, 4'hF, 1'b1);
      total++;
      if (hit !== 1'b1 || cnt !== 2'd1 || ovf !== 1'b0)
         $display("FAIL clr_with_hit: hit/cnt/ovf=%b/%0d/%b required 1/1/0", hit, cnt, ovf);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b1, 4'h0, 1'b1);
      step(1'b1, 1'b1, 4'hF, 1'b0);
      step(1'b1, 1'b1, 4'hF, 1'b0);
      step(1'b0, 1'b1, 4'hF, 1'b0);
      total++;
      if ({hit, busy, ovf, cnt} !== {1'b0, 1'b0, 1'b0, 2'd0})
         $display("FAIL reset_mid_arm: hit/busy/ovf/cnt=%b/%b/%b/%0d required 0/0/0/0", hit, busy, ovf, cnt);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hF, 1'b0);
      step(1'b0, 1'b1, 4'hF, 1'b0);
      total++;
      if ({hit, busy, cnt} !== {1'b0, 1'b0, 2'd0})
         $display("FAIL reset_mid_hit: hit/busy/cnt=%b/%b/%0d required 0/0/0", hit, busy, cnt);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic             r_v, en_v, clr_v;
      logic [WIDTH-1:0] y_v;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) PAT = WIDTH'($urandom);
         r_v   = ($urandom_range(0, 59) != 0);
         en_v  = ($urandom_range(0, 9) != 0);
         clr_v = ($urandom_range(0, 29) == 0);
         y_v   = ($urandom_range(0, 3) != 0) ? PAT : WIDTH'($urandom);
         step(r_v, en_v, y_v, clr_v);
         total++;
         if ({hit, busy, ovf, cnt} !== {m_hit, m_busy, m_ovf, CNT_W'(m_cnt)})
            $display("FAIL random[%0d]: hit/busy/ovf/cnt=%b/%b/%b/%0d required %b/%b/%b/%0d",
                     i, hit, busy, ovf, cnt, m_hit, m_busy, m_ovf, m_cnt);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_broken();
      test_en_gating();
      test_rearm();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/shift_pattern_monitor.md
Name: shift_pattern_monitor

Overview:
- Downstream consumer of the 4-bit bidirectional shift-register output Y.
- Watches Y every clock and detects when it equals a programmable pattern PAT for HOLD consecutive enabled samples.
- On detection it emits a one-cycle hit pulse and keeps a saturating event count, so the shift-register fill behaviour can be observed by control logic or LEDs.

Parameters:
- WIDTH, 4, width of Y and PAT.
- HOLD, 3, consecutive matching samples required before a hit; legal range 1..15.
- CNT_W, 8, width of the event counter.

Ports:
- clk  input  1  rising-edge clock.
- R  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- en  input  1  sample enable; when 0, the detection FSM abandons any partial match.
- Y  input  WIDTH  parallel output of the upstream shift register.
- PAT  input  WIDTH  target pattern; sampled every cycle, must be held stable by the user.
- clr  input  1  synchronous clear of cnt and ovf.
- hit  output  1  one-cycle pulse per detected event (registered).
- cnt  output  CNT_W  number of hits since reset/clr, saturating.
- ovf  output  1  sticky; set when a hit occurs while cnt is all-ones.
- busy  output  1  high whenever the FSM is not IDLE (registered state decode).

Behaviour:
- Reset (R=0 at a rising edge): state=IDLE, hcnt=0, hit=0, cnt=0, ovf=0, busy=0. R has priority over every other input, including clr and en.
- match = (Y == PAT); only samples taken at rising edges count.
- hcnt: internal 4-bit count of consecutive matching samples taken with en=1.
- FSM states and transitions:
  - IDLE: if en & match, then hcnt=1. If HOLD==1, go to LOCK with hit; else go to ARM. Otherwise stay and keep hcnt=0.
  - ARM: if ~en | ~match, go to IDLE with hcnt=0 and no hit. Else hcnt=hcnt+1. When the new hcnt equals HOLD, go to LOCK and hit=1 at that edge.
  - LOCK: stay while en & match, with no further hits. On ~match or ~en, go to IDLE with hcnt=0. A fresh hit therefore requires at least one non-matching or disabled sample first.
- hit is registered: high for exactly the one cycle after the edge on which the HOLD-th consecutive match is sampled.
- Latency: first matching sample at edge k gives hit high from edge k+HOLD-1 to edge k+HOLD.
- cnt:
  - Increments at the same edge that sets hit; holds at all-ones.
  - If a hit occurs while cnt is all-ones, cnt stays put and ovf is set to 1.
  - ovf stays set until R or clr.
- clr at the same edge as a hit: clear takes priority, then the hit is applied, giving cnt=1 and ovf=0. clr never affects the FSM or hit.
- PAT change mid-match: if match is lost, the next edge returns the FSM to IDLE (normal mismatch path).
- Reset mid-ARM or mid-LOCK: immediate return to IDLE at that edge. No hit, and any in-flight hit pulse is cleared.
- busy is high in ARM and LOCK, low in IDLE.

Test Plan:
- Reset: hold R=0 for 2 clocks with Y=4'b1111 and PAT=4'b1111 -> hit=0, cnt=0, ovf=0, busy=0 throughout. Release R -> first match is sampled on the next edge.
- Basic detect (HOLD=3, PAT=1111, en=1): Y sequence 0001, 0011, 0111, 1111, 1111, 1111, 1111, 0000 -> exactly one hit pulse, one cycle after the 3rd consecutive 1111 sample; cnt=1; busy high from the first 1111 sample until after the 0000 sample.
- Broken run: Y sequence 1111, 1111, 0111, 1111, 1111, 1111 -> the first pair gives no hit; the FSM returns to IDLE; a single hit follows the final 3rd match; cnt=1.
- en gating: Y held at 1111 with en low on the 2nd sample -> FSM returns to IDLE and the count restarts. 3 further enabled matches -> one hit.
- Re-arm: run 1111 x4, 0000, 1111 x3 -> two hits, cnt=2. No hit is produced while held in LOCK.
- Saturation/clr (CNT_W=2): generate 5 hits -> cnt sequence 1, 2, 3, 3, 3; ovf set on the 4th hit. clr asserted on the same edge as a 6th hit -> cnt=1, ovf=0.
